// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain arbiter: N_CH channel FIFOs feed one valid/ready stream through a 2-entry buffer.
// Optional macro ARB_BURST_EN keeps the grant on one channel for up to BURST_LEN consecutive reads.
module fifo_rr_drain_arb #(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 4,
  parameter int CH_BIT    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH-1:0]         fifo_empty,
  input  logic [N_CH*WIDTH-1:0]   fifo_out,
  output logic [N_CH-1:0]         fifo_ren,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_BIT-1:0]       out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  if (N_CH < 2 || N_CH > 16 || (1 << CH_BIT) < N_CH || BURST_LEN < 1) begin : g_cfg_check
    $error("fifo_rr_drain_arb: invalid parameter combination");
  end

  logic [N_CH-1:0]   req;
  logic [CH_BIT-1:0] last_grant;
  logic [CH_BIT-1:0] rr_gnt;
  logic [CH_BIT-1:0] cand;
  logic              rr_any;
  logic [CH_BIT-1:0] sel;
  logic              issue;
  logic              pop;
  logic              push;
  logic [2:0]        occ;
  logic              room;
  logic              rd_pend_p1;
  logic [CH_BIT-1:0] pend_ch_p1;
  logic [WIDTH-1:0]  cap_data;
  logic [1:0]        buf_cnt;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [WIDTH-1:0]  buf_data [2];
  logic [CH_BIT-1:0] buf_ch   [2];

  // Channel index base+k modulo N_CH; k never exceeds N_CH so one subtraction suffices.
  function automatic logic [CH_BIT-1:0] wrap_inc(input logic [CH_BIT-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CH) s = s - N_CH;
    return CH_BIT'(s);
  endfunction

  assign req = ch_en & ~fifo_empty;

  always_comb begin
    rr_gnt = last_grant;
    rr_any = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = wrap_inc(last_grant, k);
      if (!rr_any && req[cand]) begin
        rr_gnt = cand;
        rr_any = 1'b1;
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int              BC_W      = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0] BURST_MAX = BC_W'(BURST_LEN);

  logic [BC_W-1:0] burst_cnt;
  logic            hold;

  // burst_cnt counts grants already given to last_grant in the current burst.
  assign hold = (burst_cnt != '0) && (burst_cnt < BURST_MAX) && req[last_grant];
  assign sel  = hold ? last_grant : rr_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (issue) begin
      burst_cnt <= hold ? burst_cnt + 1'b1 : BC_W'(1);
    end else if (!req[last_grant]) begin
      burst_cnt <= '0;
    end
  end
`else
  assign sel = rr_gnt;
`endif

  // Outstanding words = in-flight read + buffered words; a same-cycle pop frees one slot.
  assign pop   = out_valid & out_ready;
  assign push  = rd_pend_p1;
  assign occ   = {2'b00, rd_pend_p1} + {1'b0, buf_cnt};
  assign room  = pop ? (occ < 3'd3) : (occ < 3'd2);
  assign issue = rr_any & room & ~rst;

  always_comb begin
    fifo_ren = '0;
    if (issue) fifo_ren[sel] = 1'b1;
  end

  // Stage p0 -> p1: read issued, FIFO returns its registered word next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CH_BIT'(N_CH - 1);
      rd_pend_p1 <= 1'b0;
      pend_ch_p1 <= '0;
    end else begin
      rd_pend_p1 <= issue;
      if (issue) begin
        last_grant <= sel;
        pend_ch_p1 <= sel;
      end
    end
  end

  assign cap_data = fifo_out[int'(pend_ch_p1)*WIDTH +: WIDTH];

  // Stage p1 -> buffer: returned word and its channel land in the tail entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_ch[0]   <= '0;
      buf_ch[1]   <= '0;
    end else if (push) begin
      buf_data[wr_ptr] <= cap_data;
      buf_ch[wr_ptr]   <= pend_ch_p1;
    end
  end

  assign out_data  = buf_data[rd_ptr];
  assign out_ch    = buf_ch[rd_ptr];
  assign out_valid = (buf_cnt != 2'd0);
  assign busy      = rd_pend_p1 | out_valid;

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Scoreboard bench for fifo_rr_drain_arb: behavioural channel FIFOs, directed vectors, decoupled monitor.
module tb_fifo_rr_drain_arb;
  localparam int WIDTH     = 8;
  localparam int N_CH      = 4;
  localparam int CH_BIT    = 2;
  localparam int BURST_LEN = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       fifo_empty;
  logic [N_CH*WIDTH-1:0] fifo_out;
  logic [N_CH-1:0]       fifo_ren;
  logic [WIDTH-1:0]      out_data;
  logic [CH_BIT-1:0]     out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_rr_drain_arb #(
    .WIDTH(WIDTH), .N_CH(N_CH), .CH_BIT(CH_BIT), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .fifo_empty(fifo_empty), .fifo_out(fifo_out),
    .fifo_ren(fifo_ren), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  // Channel FIFO models: registered read data, empty derived from the current count.
  logic             clr;
  logic             ld_en;
  int               ld_ch;
  logic [WIDTH-1:0] ld_data;
  bit   [WIDTH-1:0] fmem [N_CH][32];
  int               fwp  [N_CH];
  int               frp  [N_CH];
  bit   [WIDTH-1:0] fout [N_CH];

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (clr) begin
        fwp[i]  <= 0;
        frp[i]  <= 0;
        fout[i] <= '0;
      end else begin
        if (ld_en && ld_ch == i) begin
          fmem[i][fwp[i] % 32] <= ld_data;
          fwp[i] <= fwp[i] + 1;
        end
        if (fifo_ren[i]) begin
          fout[i] <= fmem[i][frp[i] % 32];
          frp[i]  <= frp[i] + 1;
        end
      end
    end
  end

  always_comb begin
    fifo_empty = '1;
    fifo_out   = '0;
    for (int i = 0; i < N_CH; i++) begin
      fifo_empty[i]               = (fwp[i] == frp[i]);
      fifo_out[i*WIDTH +: WIDTH]  = fout[i];
    end
  end

  // Expected stream (written by stimulus) and per-cycle expectations.
  logic [CH_BIT-1:0] exp_ch   [64];
  logic [WIDTH-1:0]  exp_data [64];
  int                exp_wr = 0;
  int                exp_rd = 0;
  logic [N_CH-1:0]   seq_ren  [48];
  logic              seq_vld  [48];
  logic [N_CH-1:0]   exp_ren;
  logic              exp_vld;
  logic              chk_cyc, chk_idle, chk_mask, chk_drain;

  int checks   = 0;
  int failures = 0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [CH_BIT-1:0] held_ch;

  always @(negedge clk) begin
    if (chk_idle) begin
      checks++;
      if (fifo_ren != '0 || out_valid || busy || out_data != '0 || out_ch != '0) begin
        failures++;
        $display("FAIL idle_state ren=%b valid=%b busy=%b data=%02h ch=%0d, required all zero",
                 fifo_ren, out_valid, busy, out_data, out_ch);
      end
    end
    if (chk_cyc) begin
      checks++;
      if (fifo_ren !== exp_ren || out_valid !== exp_vld) begin
        failures++;
        $display("FAIL cycle_ctrl t=%0t ren=%b valid=%b, required ren=%b valid=%b",
                 $time, fifo_ren, out_valid, exp_ren, exp_vld);
      end
    end
    if (chk_mask) begin
      checks++;
      if (fifo_ren[1]) begin
        failures++;
        $display("FAIL masked_grant ren=%b, required bit1=0", fifo_ren);
      end
    end
    if (fifo_ren != '0) begin
      checks++;
      if ((fifo_ren & fifo_empty) != '0) begin
        failures++;
        $display("FAIL ren_on_empty ren=%b empty=%b, required no overlap", fifo_ren, fifo_empty);
      end
    end
    if (stall_prev && out_valid && !rst) begin
      checks++;
      if (out_data !== held_data || out_ch !== held_ch) begin
        failures++;
        $display("FAIL stall_hold data=%02h ch=%0d, required data=%02h ch=%0d",
                 out_data, out_ch, held_data, held_ch);
      end
    end
    stall_prev = out_valid && !out_ready && !rst;
    held_data  = out_data;
    held_ch    = out_ch;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_rd >= exp_wr) begin
        failures++;
        $display("FAIL sb_unexpected got ch=%0d data=%02h, required no output", out_ch, out_data);
      end else begin
        if (out_ch !== exp_ch[exp_rd] || out_data !== exp_data[exp_rd]) begin
          failures++;
          $display("FAIL sb_word idx=%0d got ch=%0d data=%02h, required ch=%0d data=%02h",
                   exp_rd, out_ch, out_data, exp_ch[exp_rd], exp_data[exp_rd]);
        end
        exp_rd++;
      end
    end
    if (chk_drain) begin
      checks++;
      if (exp_rd != exp_wr) begin
        failures++;
        $display("FAIL sb_drain delivered=%0d, required=%0d", exp_rd, exp_wr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b1;
    step();
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic load(input int ch, input logic [WIDTH-1:0] d);
    ld_ch   = ch;
    ld_data = d;
    ld_en   = 1'b1;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic push_exp(input int ch, input logic [WIDTH-1:0] d);
    exp_ch[exp_wr]   = CH_BIT'(ch);
    exp_data[exp_wr] = d;
    exp_wr++;
  endtask

  task automatic set_step(input int i, input int ren, input logic vld);
    seq_ren[i] = N_CH'(ren);
    seq_vld[i] = vld;
  endtask

  // Plays the expectation table; optionally releases out_ready or pulses rst at a given step.
  task automatic run_seq(input int n, input int rdy_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i == rdy_at) out_ready = 1'b1;
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst       = 1'b0;
        ch_en     = '1;
        out_ready = 1'b1;
      end
      exp_ren = seq_ren[i];
      exp_vld = seq_vld[i];
      chk_cyc = 1'b1;
      step();
    end
    chk_cyc = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_rd != exp_wr && n < limit) begin
      step();
      n++;
    end
    chk_drain = 1'b1;
    step();
    chk_drain = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord_ren [8];
    int ord_ch  [8];
    logic [WIDTH-1:0] ord_d [8];

    rst = 1'b1; clr = 1'b1; ch_en = '0; out_ready = 1'b0;
    ld_en = 1'b0; ld_ch = 0; ld_data = '0;
    exp_ren = '0; exp_vld = 1'b0;
    chk_cyc = 1'b0; chk_idle = 1'b0; chk_mask = 1'b0; chk_drain = 1'b0;
    step();
    step();
    rst = 1'b0; clr = 1'b0;

    // Reset then idle with every FIFO empty.
    ch_en = '1; out_ready = 1'b1; chk_idle = 1'b1;
    repeat (10) step();
    chk_idle = 1'b0;

    // Single word on channel 2: read at t, visible at t+2 for one cycle.
    ch_en = '0;
    load(2, 8'hA5);
    push_exp(2, 8'hA5);
    set_step(0, 4'b0100, 1'b0);
    set_step(1, 0, 1'b0);
    set_step(2, 0, 1'b1);
    set_step(3, 0, 1'b0);
    ch_en = '1;
    run_seq(4, -1, -1);
    drain(10);

    // Fairness: four channels with three words each under continuous out_ready.
    do_reset();
    ch_en = '0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N_CH; c++) load(c, WIDTH'(16 * (c + 1) + k));
`ifdef ARB_BURST_EN
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < 3; k++) push_exp(c, WIDTH'(16 * (c + 1) + k));
    for (int i = 0; i < 12; i++) set_step(i, 1 << (i / 3), i >= 2);
`else
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N_CH; c++) push_exp(c, WIDTH'(16 * (c + 1) + k));
    for (int i = 0; i < 12; i++) set_step(i, 1 << (i % 4), i >= 2);
`endif
    set_step(12, 0, 1'b1);
    set_step(13, 0, 1'b1);
    set_step(14, 0, 1'b0);
    ch_en = '1;
    run_seq(15, -1, -1);
    drain(20);

    // Backpressure: five words on ch0, consumer stalled for 8 cycles.
    do_reset();
    ch_en = '0; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load(0, WIDTH'(8'h50 + k));
      push_exp(0, WIDTH'(8'h50 + k));
    end
    set_step(0, 1, 1'b0);
    set_step(1, 1, 1'b0);
    for (int i = 2; i < 8; i++) set_step(i, 0, 1'b1);
    for (int i = 8; i < 11; i++) set_step(i, 1, 1'b1);
    set_step(11, 0, 1'b1);
    set_step(12, 0, 1'b1);
    set_step(13, 0, 1'b0);
    ch_en = '1;
    run_seq(14, 8, -1);
    drain(20);

    // Mask: ch1 holds words but is disabled.
    do_reset();
    ch_en = '0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load(0, WIDTH'(8'h60 + k));
      load(1, WIDTH'(8'h70 + k));
      load(2, WIDTH'(8'h80 + k));
      load(3, WIDTH'(8'h90 + k));
    end
`ifdef ARB_BURST_EN
    ord_ren = '{1, 1, 4, 4, 8, 8, 0, 0};
    ord_ch  = '{0, 0, 2, 2, 3, 3, 0, 0};
    ord_d   = '{8'h60, 8'h61, 8'h80, 8'h81, 8'h90, 8'h91, 8'h00, 8'h00};
`else
    ord_ren = '{1, 4, 8, 1, 4, 8, 0, 0};
    ord_ch  = '{0, 2, 3, 0, 2, 3, 0, 0};
    ord_d   = '{8'h60, 8'h80, 8'h90, 8'h61, 8'h81, 8'h91, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 6; i++) push_exp(ord_ch[i], ord_d[i]);
    for (int i = 0; i < 8; i++) set_step(i, ord_ren[i], i >= 2);
    set_step(8, 0, 1'b0);
    ch_en = 4'b1101; chk_mask = 1'b1;
    run_seq(9, -1, -1);
    drain(10);
    chk_mask = 1'b0;

    // Mid-operation reset with two words buffered; those words are discarded.
    ch_en = '0; out_ready = 1'b0;
    load(3, 8'hC0);
    load(3, 8'hC1);
    load(3, 8'hC2);
    load(0, 8'hA0);
`ifdef ARB_BURST_EN
    ord_ren = '{1, 2, 2, 8, 0, 0, 0, 0};
    ord_ch  = '{0, 1, 1, 3, 0, 0, 0, 0};
    ord_d   = '{8'hA0, 8'h70, 8'h71, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    ord_ren = '{1, 2, 8, 2, 0, 0, 0, 0};
    ord_ch  = '{0, 1, 3, 1, 0, 0, 0, 0};
    ord_d   = '{8'hA0, 8'h70, 8'hC2, 8'h71, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    for (int i = 0; i < 4; i++) push_exp(ord_ch[i], ord_d[i]);
    set_step(0, 8, 1'b0);
    set_step(1, 8, 1'b0);
    set_step(2, 0, 1'b1);
    set_step(3, 0, 1'b1);
    for (int i = 0; i < 4; i++) set_step(4 + i, ord_ren[i], i >= 2);
    set_step(8, 0, 1'b1);
    set_step(9, 0, 1'b1);
    set_step(10, 0, 1'b0);
    ch_en = 4'b1000;
    run_seq(11, -1, 3);
    drain(10);

    // Burst pattern: ch0 holds six words, ch1 two.
    do_reset();
    ch_en = '0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) load(0, WIDTH'(8'hD0 + k));
    load(1, 8'hE0);
    load(1, 8'hE1);
`ifdef ARB_BURST_EN
    ord_ren = '{1, 1, 1, 1, 2, 2, 1, 1};
    ord_ch  = '{0, 0, 0, 0, 1, 1, 0, 0};
    ord_d   = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1, 8'hD4, 8'hD5};
`else
    ord_ren = '{1, 2, 1, 2, 1, 1, 1, 1};
    ord_ch  = '{0, 1, 0, 1, 0, 0, 0, 0};
    ord_d   = '{8'hD0, 8'hE0, 8'hD1, 8'hE1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
`endif
    for (int i = 0; i < 8; i++) push_exp(ord_ch[i], ord_d[i]);
    for (int i = 0; i < 8; i++) set_step(i, ord_ren[i], i >= 2);
    set_step(8, 0, 1'b1);
    set_step(9, 0, 1'b1);
    set_step(10, 0, 1'b0);
    ch_en = '1;
    run_seq(11, -1, -1);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
